// File: rtl/rip_mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / memory-access arbiter.
//   rip_const : default constants (data width, starvation limit)
//   rip_type  : mem_owner_t, the source of the read response due next cycle
package rip_const;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

package rip_type;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } mem_owner_t;
endpackage

// File: rtl/rip_mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch IF, data MA), the arbiter and
// a single-port synchronous memory.
//   slave  : arbiter view (requests and mem_dout in; grants, responses, mem_* out)
//   master : requester/memory view (the mirror image)
interface rip_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ma_req;
  logic [3:0]            ma_we;
  logic [DATA_WIDTH-1:0] ma_addr;
  logic [DATA_WIDTH-1:0] ma_wdata;
  logic                  ma_gnt;
  logic                  ma_rvalid;
  logic [DATA_WIDTH-1:0] ma_rdata;

  logic                  mem_re;
  logic [3:0]            mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  ma_req, ma_we, ma_addr, ma_wdata,
    input  mem_dout,
    output if_gnt, if_rvalid, if_rdata,
    output ma_gnt, ma_rvalid, ma_rdata,
    output mem_re, mem_we, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, if_flush,
    output ma_req, ma_we, ma_addr, ma_wdata,
    output mem_dout,
    input  if_gnt, if_rvalid, if_rdata,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  mem_re, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/rip_arb_starve_counter.sv
// Saturating count of consecutive MA grants taken while IF was waiting.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : MA granted while IF requests
//   clr       : IF granted, or IF not requesting (clear wins over inc)
//   at_limit  : count has reached LIMIT; IF must win the next conflict
module rip_arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] count_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= '0;
    end else if (clr) begin
      count_p1 <= '0;
    end else if (inc && (count_p1 != LIMIT_C)) begin
      count_p1 <= count_p1 + 4'd1;
    end
  end

  assign at_limit = (count_p1 == LIMIT_C);
endmodule

// File: rtl/rip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// MA (data) normally wins; after STARVE_LIMIT consecutive MA wins against a
// waiting IF (fetch), IF is granted once. Grants are combinational; the read
// response appears one cycle later and is routed by the registered owner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rip_mem_arbiter_if.slave (requests, grants, responses, memory)
module rip_mem_arbiter
  import rip_type::*;
#(
  parameter int DATA_WIDTH   = rip_const::DATA_WIDTH_DEF,
  parameter int STARVE_LIMIT = rip_const::STARVE_LIMIT_DEF
) (
  input logic              clk,
  input logic              rst,
  rip_mem_arbiter_if.slave bus
);
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return a & ~DATA_WIDTH'(3);
  endfunction

  logic       starve_hit;
  logic       ma_gnt_c;
  logic       if_gnt_c;
  logic       ma_read_c;
  mem_owner_t owner_nxt;
  mem_owner_t owner_p1;
  logic       flush_p1;

  // Grant stage: rst gates grants so nothing reaches memory while in reset.
  always_comb begin
    ma_gnt_c  = !rst && bus.ma_req && !(starve_hit && bus.if_req);
    if_gnt_c  = !rst && bus.if_req && !ma_gnt_c;
    ma_read_c = ma_gnt_c && (bus.ma_we == 4'b0000);
  end

  rip_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (ma_gnt_c && bus.if_req),
    .clr      (if_gnt_c || !bus.if_req),
    .at_limit (starve_hit)
  );

  assign bus.if_gnt = if_gnt_c;
  assign bus.ma_gnt = ma_gnt_c;

  always_comb begin
    bus.mem_re   = 1'b0;
    bus.mem_we   = 4'b0000;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (ma_gnt_c) begin
      bus.mem_re   = ma_read_c;
      bus.mem_we   = bus.ma_we;
      bus.mem_addr = word_align(bus.ma_addr);
      bus.mem_din  = bus.ma_wdata;
    end else if (if_gnt_c) begin
      bus.mem_re   = 1'b1;
      bus.mem_addr = word_align(bus.if_addr);
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (ma_read_c) begin
      owner_nxt = OWN_MA;
    end else if (if_gnt_c) begin
      owner_nxt = OWN_IF;
    end
  end

  // Response stage: owner selects who sees mem_dout; flush_p1 remembers a
  // flush raised in the fetch grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p1 <= OWN_NONE;
      flush_p1 <= 1'b0;
    end else begin
      owner_p1 <= owner_nxt;
      flush_p1 <= if_gnt_c && bus.if_flush;
    end
  end

  assign bus.if_rvalid = (owner_p1 == OWN_IF) && !flush_p1 && !bus.if_flush;
  assign bus.ma_rvalid = (owner_p1 == OWN_MA);
  assign bus.if_rdata  = bus.mem_dout;
  assign bus.ma_rdata  = bus.mem_dout;
endmodule

// File: tb/tb_rip_mem_arbiter.sv
// Self-checking bench for rip_mem_arbiter: reset state, a directed vector
// table, hand-written starvation and reset-mid-read sequences, then random
// traffic against a behavioural model.
module tb_rip_mem_arbiter;
  import rip_type::*;

  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rip_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  rip_mem_arbiter #(
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        ma_req;
    logic [3:0]  ma_we;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdata;
    logic [31:0] mem_dout;
    logic        e_if_gnt;
    logic        e_ma_gnt;
    logic        e_re;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic        e_if_rv;
    logic        e_ma_rv;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic i_req, input logic [31:0] i_addr, input logic i_fl,
    input logic m_req, input logic [3:0] m_we, input logic [31:0] m_addr,
    input logic [31:0] m_wd, input logic [31:0] dout,
    input logic eig, input logic emg, input logic ere, input logic [3:0] ewe,
    input logic [31:0] eaddr, input logic [31:0] edin,
    input logic eirv, input logic emrv, input logic [31:0] erd);
    vec_t v;
    v.if_req = i_req; v.if_addr = i_addr; v.if_flush = i_fl;
    v.ma_req = m_req; v.ma_we = m_we; v.ma_addr = m_addr; v.ma_wdata = m_wd;
    v.mem_dout = dout;
    v.e_if_gnt = eig; v.e_ma_gnt = emg; v.e_re = ere; v.e_we = ewe;
    v.e_addr = eaddr; v.e_din = edin; v.e_if_rv = eirv; v.e_ma_rv = emrv;
    v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i_req, input logic [31:0] i_addr, input logic i_fl,
                       input logic m_req, input logic [3:0] m_we, input logic [31:0] m_addr,
                       input logic [31:0] m_wd, input logic [31:0] dout);
    bus.if_req   = i_req;
    bus.if_addr  = i_addr;
    bus.if_flush = i_fl;
    bus.ma_req   = m_req;
    bus.ma_we    = m_we;
    bus.ma_addr  = m_addr;
    bus.ma_wdata = m_wd;
    bus.mem_dout = dout;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[12];

  // Random-phase reference model state
  int   m_starve;
  int   m_resp;      // 0: nothing due, 1: fetch data due, 2: load data due
  bit   m_resp_fl;
  bit   m_if_hold;
  bit   m_ma_hold;

  initial begin
    logic        e_ma, e_if, e_re, e_if_rv, e_ma_rv;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_din;
    logic [31:0] a_tmp;
    logic        starve_pat[6];

    checks   = 0;
    failures = 0;

    // Reset state with both requesters active: nothing may be granted.
    rst = 1'b1;
    drive(1, 32'h0000_0010, 0, 1, 4'b0000, 32'h0000_0020, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_ma_gnt", 32'(bus.ma_gnt), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_ma_rvalid", 32'(bus.ma_rvalid), 32'd0);
    chk("rst_owner", 32'(dut.owner_p1), 32'(OWN_NONE));
    do_reset();

    // Directed vectors, applied one per cycle from a fresh reset.
    tbl[0]  = mk(0, 32'h0,   0, 0, 4'b0000, 32'h0,   32'h0,       32'h0,       0, 0, 0, 4'b0000, 32'h0,   32'h0,       0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h103, 0, 0, 4'b0000, 32'h0,   32'h0,       32'h0,       1, 0, 1, 4'b0000, 32'h100, 32'h0,       0, 0, 32'h0);
    tbl[2]  = mk(0, 32'h0,   0, 0, 4'b0000, 32'h0,   32'h0,       32'hDEADBEEF,0, 0, 0, 4'b0000, 32'h0,   32'h0,       1, 0, 32'hDEADBEEF);
    tbl[3]  = mk(1, 32'h40,  0, 1, 4'b0011, 32'h20,  32'h0000A5A5,32'h0,       0, 1, 0, 4'b0011, 32'h20,  32'h0000A5A5,0, 0, 32'h0);
    tbl[4]  = mk(1, 32'h40,  0, 0, 4'b0000, 32'h0,   32'h0,       32'h5555,    1, 0, 1, 4'b0000, 32'h40,  32'h0,       0, 0, 32'h0);
    tbl[5]  = mk(0, 32'h0,   1, 1, 4'b0000, 32'h104, 32'h0,       32'h1111,    0, 1, 1, 4'b0000, 32'h104, 32'h0,       0, 0, 32'h0);
    tbl[6]  = mk(0, 32'h0,   0, 1, 4'b0000, 32'h208, 32'h0,       32'h2222,    0, 1, 1, 4'b0000, 32'h208, 32'h0,       0, 1, 32'h2222);
    tbl[7]  = mk(0, 32'h0,   0, 1, 4'b0000, 32'h30E, 32'h0,       32'h3333,    0, 1, 1, 4'b0000, 32'h30C, 32'h0,       0, 1, 32'h3333);
    tbl[8]  = mk(0, 32'h0,   0, 0, 4'b0000, 32'h0,   32'h0,       32'h4444,    0, 0, 0, 4'b0000, 32'h0,   32'h0,       0, 1, 32'h4444);
    tbl[9]  = mk(0, 32'h0,   0, 0, 4'b0000, 32'h0,   32'h0,       32'h0,       0, 0, 0, 4'b0000, 32'h0,   32'h0,       0, 0, 32'h0);
    tbl[10] = mk(1, 32'h13,  1, 0, 4'b0000, 32'h0,   32'h0,       32'h0,       1, 0, 1, 4'b0000, 32'h10,  32'h0,       0, 0, 32'h0);
    tbl[11] = mk(0, 32'h0,   0, 0, 4'b0000, 32'h0,   32'h0,       32'h6666,    0, 0, 0, 4'b0000, 32'h0,   32'h0,       0, 0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].if_flush, tbl[i].ma_req, tbl[i].ma_we,
            tbl[i].ma_addr, tbl[i].ma_wdata, tbl[i].mem_dout);
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 32'(bus.if_gnt), 32'(tbl[i].e_if_gnt));
      chk($sformatf("v%0d_ma_gnt", i), 32'(bus.ma_gnt), 32'(tbl[i].e_ma_gnt));
      chk($sformatf("v%0d_mem_re", i), 32'(bus.mem_re), 32'(tbl[i].e_re));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_din", i), bus.mem_din, tbl[i].e_din);
      chk($sformatf("v%0d_if_rvalid", i), 32'(bus.if_rvalid), 32'(tbl[i].e_if_rv));
      chk($sformatf("v%0d_ma_rvalid", i), 32'(bus.ma_rvalid), 32'(tbl[i].e_ma_rv));
      if (tbl[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, tbl[i].e_rdata);
      if (tbl[i].e_ma_rv) chk($sformatf("v%0d_ma_rdata", i), bus.ma_rdata, tbl[i].e_rdata);
    end

    // Starvation: both held high; MA wins four times, then IF once, then MA.
    do_reset();
    starve_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      drive(1, 32'h80, 0, 1, 4'b0000, 32'h90, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("starve_c%0d_ma_gnt", c), 32'(bus.ma_gnt), 32'(starve_pat[c]));
      chk($sformatf("starve_c%0d_if_gnt", c), 32'(bus.if_gnt), 32'(!starve_pat[c]));
    end

    // Reset mid-read: MA read granted, reset lands during the response cycle.
    do_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, 4'b0000, 32'h50, 32'h0, 32'h0);
    @(negedge clk);
    chk("rmr_ma_gnt", 32'(bus.ma_gnt), 32'd1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h7777);
    #1;
    chk("rmr_pre_rvalid", 32'(bus.ma_rvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmr_ma_rvalid", 32'(bus.ma_rvalid), 32'd0);
    chk("rmr_owner", 32'(dut.owner_p1), 32'(OWN_NONE));
    chk("rmr_mem_re", 32'(bus.mem_re), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rmr_post%0d_ma_rvalid", c), 32'(bus.ma_rvalid), 32'd0);
      chk($sformatf("rmr_post%0d_if_rvalid", c), 32'(bus.if_rvalid), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    m_starve  = 0;
    m_resp    = 0;
    m_resp_fl = 1'b0;
    m_if_hold = 1'b0;
    m_ma_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (!m_if_hold) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end
      if (!m_ma_hold) begin
        bus.ma_req   = ($urandom_range(0, 2) != 0);
        a_tmp        = $urandom;
        bus.ma_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : a_tmp[3:0];
        bus.ma_addr  = $urandom;
        bus.ma_wdata = $urandom;
      end
      bus.if_flush = ($urandom_range(0, 3) == 0);
      bus.mem_dout = $urandom;
      @(negedge clk);

      e_ma    = bus.ma_req && !((m_starve == LIMIT) && bus.if_req);
      e_if    = bus.if_req && !e_ma;
      e_re    = (e_ma && (bus.ma_we == 4'b0000)) || e_if;
      e_we    = e_ma ? bus.ma_we : 4'b0000;
      e_addr  = e_ma ? {bus.ma_addr[31:2], 2'b00} : (e_if ? {bus.if_addr[31:2], 2'b00} : 32'h0);
      e_din   = e_ma ? bus.ma_wdata : 32'h0;
      e_if_rv = (m_resp == 1) && !m_resp_fl && !bus.if_flush;
      e_ma_rv = (m_resp == 2);

      chk("rnd_if_gnt", 32'(bus.if_gnt), 32'(e_if));
      chk("rnd_ma_gnt", 32'(bus.ma_gnt), 32'(e_ma));
      chk("rnd_mem_re", 32'(bus.mem_re), 32'(e_re));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("rnd_mem_addr", bus.mem_addr, e_addr);
      chk("rnd_mem_din", bus.mem_din, e_din);
      chk("rnd_if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
      chk("rnd_ma_rvalid", 32'(bus.ma_rvalid), 32'(e_ma_rv));
      if (e_if_rv) chk("rnd_if_rdata", bus.if_rdata, bus.mem_dout);
      if (e_ma_rv) chk("rnd_ma_rdata", bus.ma_rdata, bus.mem_dout);

      if (e_if || !bus.if_req) m_starve = 0;
      else if (e_ma && m_starve < LIMIT) m_starve = m_starve + 1;
      m_resp    = (e_ma && (bus.ma_we == 4'b0000)) ? 2 : (e_if ? 1 : 0);
      m_resp_fl = e_if && bus.if_flush;
      m_if_hold = bus.if_req && !e_if;
      m_ma_hold = bus.ma_req && !e_ma;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
